// File: rtl/pixel_stream_feeder.sv
// pixel_stream_feeder: fetches frame-buffer bursts from a DDR2 controller and
// streams 24-bit pixels out of an internal word FIFO.
//
// Handshakes (valid/ready):
//   af_wr_en/af_full    a request transfers on a cycle with af_wr_en && !af_full.
//                       While it is stalled, af_wr_en and af_addr_din hold.
//   px_valid/px_ready   a pixel transfers on a cycle with px_valid && px_ready.
//                       px_valid never depends on px_ready. px_data holds until
//                       the pixel is taken.
//   rdf_valid           is a push-only strobe. rdf_rd_en is tied high, so the
//                       block accepts every beat.
//
// Optional feature: define FEEDER_UNDERFLOW_CNT_EN to count the cycles in which
// the sink wants a pixel while the stream is starved. Without the macro,
// underflow_cnt is tied to zero.
module pixel_stream_feeder #(
  parameter int H_BURSTS     = 100,
  parameter int V_LINES      = 600,
  parameter int CREDIT_MAX   = 8000,
  parameter int START_THRESH = 256,
  parameter int FIFO_AW      = 13
) (
  input  logic         cpu_clk_g,
  input  logic         rst,
  input  logic         af_full,
  output logic         af_wr_en,
  output logic [30:0]  af_addr_din,
  input  logic         rdf_valid,
  input  logic [127:0] rdf_dout,
  output logic         rdf_rd_en,
  input  logic [5:0]   frame_base,
  input  logic         frame_base_wr,
  output logic [23:0]  px_data,
  output logic         px_valid,
  input  logic         px_ready,
  output logic         stream_en,
  output logic         frame_start,
  output logic [15:0]  underflow_cnt,
  output logic         state_dbg
);

  localparam int CW          = FIFO_AW + 1;
  localparam int RAW         = FIFO_AW - 2;
  localparam int FRAME_WORDS = 8 * H_BURSTS * V_LINES;

  localparam logic [6:0]    X_LAST     = 7'(H_BURSTS - 1);
  localparam logic [9:0]    Y_LAST     = 10'(V_LINES - 1);
  localparam logic [CW-1:0] CREDIT_LIM = CW'(CREDIT_MAX);
  localparam logic [CW-1:0] START_LIM  = CW'(START_THRESH);
  localparam logic [20:0]   FRAME_LAST = 21'(FRAME_WORDS - 1);

  // The credit scheme only prevents overflow if the FIFO can hold the limit
  // plus the words of two requests that are already in flight.
  if (CREDIT_MAX + 16 > (1 << FIFO_AW)) begin : g_depth_check
    $error("pixel_stream_feeder: CREDIT_MAX+16 exceeds the FIFO depth");
  end
  if (H_BURSTS < 1 || H_BURSTS > 128 || V_LINES < 1 || V_LINES > 1024) begin : g_geom_check
    $error("pixel_stream_feeder: H_BURSTS or V_LINES out of range");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      x_q;
  logic [9:0]      y_q;
  logic [5:0]      cur_base_q, pend_base_q;
  logic [CW-1:0]   credits_q, credits_d;
  logic [CW-1:0]   fill_q;
  logic [RAW-1:0]  wr_row_q;
  logic [FIFO_AW-1:0] rd_word_q;
  logic [127:0]    mem [0:(1 << RAW) - 1];
  logic            stream_en_q;
  logic [20:0]     frame_idx_q;
  logic            accept, pop, fifo_empty;
  logic [127:0]    head_row;
  logic [31:0]     head_word;
  logic [7:0]      unused_head_hi;

  assign accept     = af_wr_en && !af_full;
  assign fifo_empty = (fill_q == '0);
  assign pop        = px_valid && px_ready;

  // Credits = words requested but not yet popped. The counter never goes below
  // zero. This stops beats that are still in flight after a reset from
  // wrapping it, which would stall fetching for good.
  always_comb begin
    credits_d = credits_q;
    if (accept) credits_d = credits_d + CW'(8);
    if (pop && (accept || credits_q != '0)) credits_d = credits_d - CW'(1);
  end

  // Next-state logic. It compares against the credit level the current cycle
  // leaves behind, so fetching stops right after the request that crosses the limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (credits_d <= CREDIT_LIM) state_d = ST_FETCH;
      ST_FETCH: if (credits_d >  CREDIT_LIM) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and credit counter.
  always_ff @(posedge cpu_clk_g) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      credits_q <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
    end
  end

  assign af_wr_en    = (state_q == ST_FETCH);
  assign state_dbg   = state_q;
  assign af_addr_din = {6'b0, cur_base_q, y_q, x_q, 2'b00};
  assign rdf_rd_en   = 1'b1;

  // Burst/line position and frame buffer select. These advance only on an accepted request.
  // A base strobe in the wrap cycle goes straight into the next frame.
  always_ff @(posedge cpu_clk_g) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      cur_base_q  <= 6'd1;
      pend_base_q <= 6'd1;
    end else begin
      if (frame_base_wr) pend_base_q <= frame_base;
      if (accept) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          if (y_q == Y_LAST) begin
            y_q        <= '0;
            cur_base_q <= frame_base_wr ? frame_base : pend_base_q;
          end else begin
            y_q <= y_q + 10'd1;
          end
        end else begin
          x_q <= x_q + 7'd1;
        end
      end
    end
  end

  // FIFO storage. Every beat is a full 4-word row, so rows stay aligned.
  always_ff @(posedge cpu_clk_g) begin
    if (rdf_valid) mem[wr_row_q] <= rdf_dout;
  end

  // FIFO pointers and fill level: a beat adds 4 words and a pop removes 1.
  always_ff @(posedge cpu_clk_g) begin
    if (rst) begin
      wr_row_q  <= '0;
      rd_word_q <= '0;
      fill_q    <= '0;
    end else begin
      if (rdf_valid) wr_row_q <= wr_row_q + RAW'(1);
      if (pop) rd_word_q <= rd_word_q + FIFO_AW'(1);
      case ({rdf_valid, pop})
        2'b10:   fill_q <= fill_q + CW'(4);
        2'b01:   fill_q <= fill_q - CW'(1);
        2'b11:   fill_q <= fill_q + CW'(3);
        default: fill_q <= fill_q;
      endcase
    end
  end

  assign head_row = mem[rd_word_q[FIFO_AW-1:2]];

  // Head word select. Words leave in order from low bits to high bits of each beat.
  always_comb begin
    head_word = head_row[31:0];
    case (rd_word_q[1:0])
      2'd0:    head_word = head_row[31:0];
      2'd1:    head_word = head_row[63:32];
      2'd2:    head_word = head_row[95:64];
      default: head_word = head_row[127:96];
    endcase
  end

  assign px_data        = head_word[23:0];
  assign unused_head_hi = head_word[31:24];

  // Streaming starts once the FIFO has built up a cushion, and it stays on until reset.
  always_ff @(posedge cpu_clk_g) begin
    if (rst) stream_en_q <= 1'b0;
    else if (fill_q > START_LIM) stream_en_q <= 1'b1;
  end

  assign stream_en = stream_en_q;
  assign px_valid  = stream_en_q && !fifo_empty;

  // Word index within the frame. It marks the first pixel of each frame.
  always_ff @(posedge cpu_clk_g) begin
    if (rst) frame_idx_q <= '0;
    else if (pop) frame_idx_q <= (frame_idx_q == FRAME_LAST) ? '0 : frame_idx_q + 21'd1;
  end

  assign frame_start = pop && (frame_idx_q == '0);

`ifdef FEEDER_UNDERFLOW_CNT_EN
  logic [15:0] underflow_q;

  // Saturating count of starved cycles.
  always_ff @(posedge cpu_clk_g) begin
    if (rst) underflow_q <= '0;
    else if (stream_en_q && px_ready && fifo_empty && underflow_q != 16'hFFFF)
      underflow_q <= underflow_q + 16'd1;
  end

  assign underflow_cnt = underflow_q;
`else
  assign underflow_cnt = 16'h0;
`endif

endmodule
